// File: rtl/motion_pattern_engine.sv
// Synthetic mouse-motion report generator: circle/square/figure-8/random/drag/idle deltas per report tick.
// Sample registers one cycle after the tick; held reports absorb later ticks by saturating accumulation.
module motion_pattern_engine #(
  parameter int          CLK_FREQ_HZ = 48_000_000,
  parameter int          REPORT_HZ   = 100,
  parameter int          DELTA_W     = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [2:0]         pattern_sel,
  input  logic [2:0]         scale,
  input  logic [1:0]         speed,
  input  logic               rpt_ready,
  output logic               rpt_valid,
  output logic [DELTA_W-1:0] dx,
  output logic [DELTA_W-1:0] dy,
  output logic [2:0]         buttons,
  output logic [7:0]         coalesce_cnt
);

  localparam int TICKS = CLK_FREQ_HZ / REPORT_HZ;
  localparam int TW    = $clog2(TICKS);

  // First quadrant of round(127*sin); the 90-degree point (127) is handled separately
  localparam logic [6:0] QW [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  typedef enum logic {IDLE, PEND} state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              tick_cnt;
  logic                       tick, xfer, load, coal;
  logic [7:0]                 p, eff_p;
  logic [2:0]                 pat_q;
  logic [15:0]                lfsr;
  logic signed [7:0]          amp, s_dx, s_dy;
  logic [2:0]                 s_btn;
  logic signed [DELTA_W-1:0]  smp_dx, smp_dy, dx_q, dy_q;

  function automatic logic signed [7:0] sine(input logic [7:0] th);
    logic [6:0] mag;
    if (th[6])
      mag = (th[5:0] == 6'd0) ? 7'd127 : QW[~th[5:0] + 6'd1];
    else
      mag = QW[th[5:0]];
    sine = th[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic signed [7:0] cosine(input logic [7:0] th);
    cosine = sine(th + 8'd64);
  endfunction

  function automatic logic signed [DELTA_W-1:0] sat_add(input logic signed [DELTA_W-1:0] a,
                                                        input logic signed [DELTA_W-1:0] b);
    logic signed [DELTA_W:0] s;
    s = (DELTA_W+1)'(a) + (DELTA_W+1)'(b);
    if (s[DELTA_W] != s[DELTA_W-1])
      sat_add = s[DELTA_W] ? {1'b1, {(DELTA_W-1){1'b0}}} : {1'b0, {(DELTA_W-1){1'b1}}};
    else
      sat_add = s[DELTA_W-1:0];
  endfunction

  assign tick = enable && (tick_cnt == TW'(TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick_cnt <= '0;
    else if (!enable || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= 8'd0;
      pat_q <= 3'd0;
      lfsr  <= LFSR_SEED;
    end else if (tick) begin
      p     <= p + (8'd1 << speed);
      pat_q <= pattern_sel;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // A pattern switch restarts the waveform from phase 0 for that sample
  assign eff_p = (pattern_sel != pat_q) ? 8'd0 : p;
  assign amp   = 8'sd64 >>> scale;

  always_comb begin
    s_dx  = 8'sd0;
    s_dy  = 8'sd0;
    s_btn = 3'b000;
    case (pattern_sel)
      3'd0: begin
        s_dx = sine(eff_p) >>> scale;
        s_dy = cosine(eff_p) >>> scale;
      end
      3'd1: begin
        case (eff_p[7:6])
          2'd0:    s_dx = amp;
          2'd1:    s_dy = amp;
          2'd2:    s_dx = -amp;
          default: s_dy = -amp;
        endcase
      end
      3'd2: begin
        s_dx = cosine(eff_p) >>> scale;
        s_dy = cosine({eff_p[6:0], 1'b0}) >>> scale;
      end
      3'd3: begin
        s_dx = $signed({4'b0000, lfsr[3:0]}) - 8'sd8;
        s_dy = $signed({4'b0000, lfsr[7:4]}) - 8'sd8;
      end
      3'd4: begin
        s_dx  = eff_p[7] ? -amp : amp;
        s_btn = eff_p[7] ? 3'b000 : 3'b001;
      end
      default: ;
    endcase
    smp_dx = DELTA_W'(s_dx);
    smp_dy = DELTA_W'(s_dy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = PEND;
      default: if (tick) state_d = PEND; else if (xfer) state_d = IDLE;
    endcase
  end

  always_comb begin
    rpt_valid = (state_q == PEND);
    xfer      = rpt_valid && rpt_ready;
    load      = tick && (!rpt_valid || xfer);
    coal      = tick && rpt_valid && !xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q         <= '0;
      dy_q         <= '0;
      buttons      <= 3'b000;
      coalesce_cnt <= 8'd0;
    end else if (load) begin
      dx_q         <= smp_dx;
      dy_q         <= smp_dy;
      buttons      <= s_btn;
      coalesce_cnt <= 8'd0;
    end else if (coal) begin
      dx_q         <= sat_add(dx_q, smp_dx);
      dy_q         <= sat_add(dy_q, smp_dy);
      buttons      <= s_btn;
      coalesce_cnt <= (coalesce_cnt == 8'hFF) ? coalesce_cnt : coalesce_cnt + 8'd1;
    end
  end

  assign dx = dx_q;
  assign dy = dy_q;

endmodule

// File: tb/tb_motion_pattern_engine.sv
// Directed bench for motion_pattern_engine with TICKS = 10 (1 kHz clock, 100 Hz reports).
module tb_motion_pattern_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] pattern_sel = 3'd0;
  logic [2:0] scale = 3'd0;
  logic [1:0] speed = 2'd0;
  logic       rpt_ready = 1'b0;
  logic       rpt_valid;
  logic [7:0] dx, dy;
  logic [2:0] buttons;
  logic [7:0] coalesce_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  motion_pattern_engine #(
    .CLK_FREQ_HZ(1000),
    .REPORT_HZ  (100),
    .DELTA_W    (8),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .scale       (scale),
    .speed       (speed),
    .rpt_ready   (rpt_ready),
    .rpt_valid   (rpt_valid),
    .dx          (dx),
    .dy          (dy),
    .buttons     (buttons),
    .coalesce_cnt(coalesce_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rpt_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_vld", 32'(rpt_valid), 0);
    chk("rst_dx", 32'($signed(dx)), 0);
    chk("rst_dy", 32'($signed(dy)), 0);
    chk("rst_btn", 32'(buttons), 0);
    chk("rst_cnt", 32'(coalesce_cnt), 0);
    rst = 1'b0;

    // Circle, scale 3: first report lands 10 cycles after enable
    pattern_sel = 3'd0; scale = 3'd3; speed = 2'd0; rpt_ready = 1'b1; enable = 1'b1;
    step(9);
    chk("circ_vld_c9", 32'(rpt_valid), 0);
    step(1);
    chk("circ_vld_c10", 32'(rpt_valid), 1);
    chk("circ_dx", 32'($signed(dx)), 0);
    chk("circ_dy", 32'($signed(dy)), 15);
    chk("circ_btn", 32'(buttons), 0);
    step(1);
    chk("circ_xfer_vld", 32'(rpt_valid), 0);
    chk("circ_hold_dy", 32'($signed(dy)), 15);
    enable = 1'b0;
    step(20);
    chk("dis_no_rpt", 32'(rpt_valid), 0);

    // Square, speed 3: eight reports in the first quadrant, then the second
    do_reset();
    pattern_sel = 3'd1; scale = 3'd0; speed = 2'd3; rpt_ready = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(10);
      chk($sformatf("sq%0d_vld", k), 32'(rpt_valid), 1);
      chk($sformatf("sq%0d_dx", k), 32'($signed(dx)), (k <= 8) ? 64 : 0);
      chk($sformatf("sq%0d_dy", k), 32'($signed(dy)), (k <= 8) ? 0 : 64);
    end

    // Backpressure: coalesce with saturation, then accept on the tick cycle
    do_reset();
    pattern_sel = 3'd1; scale = 3'd0; speed = 2'd0; rpt_ready = 1'b0; enable = 1'b1;
    step(10);
    chk("bp1_vld", 32'(rpt_valid), 1);
    chk("bp1_dx", 32'($signed(dx)), 64);
    chk("bp1_cnt", 32'(coalesce_cnt), 0);
    step(5);
    chk("bp_mid_dx", 32'($signed(dx)), 64);
    chk("bp_mid_cnt", 32'(coalesce_cnt), 0);
    step(5);
    chk("bp2_dx", 32'($signed(dx)), 127);
    chk("bp2_cnt", 32'(coalesce_cnt), 1);
    step(10);
    chk("bp3_vld", 32'(rpt_valid), 1);
    chk("bp3_dx", 32'($signed(dx)), 127);
    chk("bp3_dy", 32'($signed(dy)), 0);
    chk("bp3_cnt", 32'(coalesce_cnt), 2);
    step(9);
    chk("bp_pre_tick_dx", 32'($signed(dx)), 127);
    rpt_ready = 1'b1;
    step(1);
    chk("acc_tick_vld", 32'(rpt_valid), 1);
    chk("acc_tick_dx", 32'($signed(dx)), 64);
    chk("acc_tick_cnt", 32'(coalesce_cnt), 0);
    step(1);
    chk("xfer_notick_vld", 32'(rpt_valid), 0);
    chk("xfer_notick_dx", 32'($signed(dx)), 64);

    // Random from reset: seed ACE1 then one LFSR step gives 59C3
    do_reset();
    pattern_sel = 3'd3; scale = 3'd0; speed = 2'd0; rpt_ready = 1'b1; enable = 1'b1;
    step(10);
    chk("rnd1_dx", 32'($signed(dx)), -7);
    chk("rnd1_dy", 32'($signed(dy)), 6);
    chk("rnd1_btn", 32'(buttons), 0);
    step(10);
    chk("rnd2_dx", 32'($signed(dx)), -5);
    chk("rnd2_dy", 32'($signed(dy)), 4);
    rpt_ready = 1'b0;
    step(3);
    chk("rnd_pend_vld", 32'(rpt_valid), 1);

    // Reset while a report is pending clears outputs immediately
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(rpt_valid), 0);
    chk("mid_rst_dx", 32'($signed(dx)), 0);
    chk("mid_rst_dy", 32'($signed(dy)), 0);
    chk("mid_rst_btn", 32'(buttons), 0);
    chk("mid_rst_cnt", 32'(coalesce_cnt), 0);
    #1;
    rst = 1'b0;
    step(10);
    chk("post_rst_vld", 32'(rpt_valid), 1);
    chk("post_rst_cnt", 32'(coalesce_cnt), 0);
    chk("post_rst_dx", 32'($signed(dx)), -7);
    chk("post_rst_dy", 32'($signed(dy)), 6);

    // Drag, scale 1: button held in the first half of the phase
    do_reset();
    pattern_sel = 3'd4; scale = 3'd1; speed = 2'd0; rpt_ready = 1'b1; enable = 1'b1;
    step(10);
    chk("drag_dx", 32'($signed(dx)), 32);
    chk("drag_dy", 32'($signed(dy)), 0);
    chk("drag_btn", 32'(buttons), 1);

    // Figure-8, speed 3: phase 0 then phase 8
    do_reset();
    pattern_sel = 3'd2; scale = 3'd0; speed = 2'd3; rpt_ready = 1'b1; enable = 1'b1;
    step(10);
    chk("fig8_p0_dx", 32'($signed(dx)), 127);
    chk("fig8_p0_dy", 32'($signed(dy)), 127);
    step(10);
    chk("fig8_p8_dx", 32'($signed(dx)), 125);
    chk("fig8_p8_dy", 32'($signed(dy)), 117);

    // Idle pattern still produces (zero) reports
    do_reset();
    pattern_sel = 3'd6; scale = 3'd0; speed = 2'd0; rpt_ready = 1'b0; enable = 1'b1;
    step(10);
    chk("idle_vld", 32'(rpt_valid), 1);
    chk("idle_dx", 32'($signed(dx)), 0);
    chk("idle_dy", 32'($signed(dy)), 0);
    chk("idle_btn", 32'(buttons), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
